multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Sequencing control unit for the 8-bit multicycle MIPS datapath.
- It is the producer side of the ALU interface. It decodes opcode and funct and drives the 3-bit ALU control code.
- It consumes the ALU zero flag (FlagZ) to resolve beq.
- It is a Moore FSM that issues per-cycle enables for the IR, PC, register file and memory, plus mux selects.

Parameters:
- OP_W, 6, opcode width.
- FN_W, 6, funct width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  6  instr[31:26] from IR
- Funct  in  6  instr[5:0] from IR
- FlagZ  in  1  ALU zero flag, same cycle
- ULAControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- IorD  out  1  memory address select: 0 PC, 1 ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0 rt, 1 rd
- MemtoReg  out  1  write data: 0 ALUOut, 1 MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  SrcA: 0 PC, 1 regA
- ALUSrcB  out  2  SrcB: 00 regB, 01 const 1, 10 signimm, 11 signimm (branch offset)
- PCSrc  out  2  PC source: 00 ALUResult, 01 ALUOut, 10 jump target
- PCEn  out  1  PC load enable: PCWrite | (Branch & FlagZ)
- Illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- State  out  4  current state, debug

Behaviour:
- Encoding constants:
  - States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
  - Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Reset and arming:
  - rst_n low asynchronously sets state to FETCH, Armed to 0 and Illegal to 0.
  - While Armed=0, every enable (IRWrite, PCEn, RegWrite, MemWrite) is 0 and state holds FETCH.
  - Armed sets on the first clk edge after rst_n rises. The first real FETCH is that next cycle.
  - All selects reset to 0. ULAControl resets to 010.
- Outputs are Moore (decoded from state), except:
  - PCEn is combinational on FlagZ in BRANCH.
  - ULAControl in EXEC depends on Funct.
- Per-state outputs (unlisted enables are 0, selects don't-care but driven 0):
  - FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ULAControl=010, PCSrc=00, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ULAControl=010 (branch target precompute).
    - lw/sw go to MEMADR.
    - R goes to EXEC.
    - beq goes to BRANCH.
    - addi goes to ADDIEX.
    - j goes to JUMP.
    - Any other opcode goes to FETCH with Illegal=1 for that cycle.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ULAControl=010. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD: IorD=1, then MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
  - MEMWR: IorD=1, MemWrite=1, then FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ULAControl from Funct:
    - 100000 gives 010.
    - 100010 gives 110.
    - 100100 gives 000.
    - 100101 gives 001.
    - 101010 gives 111.
    - Any other funct gives 010, Illegal=1, and next state FETCH; ALUWB is skipped, so no register write.
    - Legal funct: next state ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ULAControl=110, PCSrc=01, Branch=1, PCEn=FlagZ, then FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ULAControl=010, then ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
  - JUMP: PCSrc=10, PCWrite=1, then FETCH.
- Latency in cycles, counted FETCH to the next FETCH:
  - lw 5
  - sw 4
  - R 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
  - illegal funct 3
- Opcode and Funct are sampled only in DECODE and EXEC. They are held stable by the IR, which loads only in FETCH.
- Unreachable state codes (12–15) go to FETCH on the next edge with all enables 0.
- rst_n asserted mid-instruction aborts it immediately, with no partial RegWrite or MemWrite after the assertion.

Decomposition:
- Shared package (mips_pkg) holds:
  - state encodings
  - opcode constants
  - funct constants
  - ULAControl codes (add/sub/and/or/slt)
  - ALUSrcB and PCSrc select codes
- One sub-module, alu_decoder: combinational Funct plus aluop to ULAControl and illegal_funct. It is reused by the single-cycle core.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release. Required: all enables 0 during reset and for 1 cycle after; then IRWrite=1, PCEn=1, State=0.
- lw (100011): State sequence 0,1,2,3,4,0. MEMRD has IorD=1. MEMWB has MemtoReg=1, RegWrite=1, RegDst=0.
- R-type with Funct=101010: EXEC drives ULAControl=111. ALUWB has RegWrite=1, RegDst=1. Total 4 cycles.
- beq with FlagZ=1 in BRANCH: PCEn=1, PCSrc=01, ULAControl=110. Repeat with FlagZ=0: PCEn=0, next State=0.
- Opcode=111111: DECODE pulses Illegal=1, next State=0, no RegWrite/MemWrite at any point. Funct=000111 on R-type: Illegal in EXEC, no ALUWB.
- Assert rst_n low during MEMWR of sw: MemWrite drops to 0 asynchronously; after release, fetch restarts from FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcode/funct values,
// ALU control codes, mux select codes and the per-state control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] ula;
  } ctrl_t;

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c     = '0;
    c.ula = ULA_ADD;
    return c;
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Control word driven while the FSM sits in state s; ula comes from alu_decoder.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] ula);
    ctrl_t c;
    c     = '0;
    c.ula = ula;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = SRCB_ONE;
        c.pcsrc   = PCSRC_ALU;
      end
      S_DECODE: c.alusrcb = SRCB_BRANCH;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REGB;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REGB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      default: c = ctrl_reset();
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Funct/aluop to 3-bit ALU control decode; shared with the single-cycle core.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  input  aluop_t     aluop,
  output logic [2:0] ula_ctrl,
  output logic       illegal_funct
);

  // Unknown functs fall back to add and flag illegal_funct.
  always_comb begin
    ula_ctrl      = ULA_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: ula_ctrl = ULA_ADD;
      ALUOP_SUB: ula_ctrl = ULA_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ula_ctrl = ULA_ADD;
          FN_SUB:  ula_ctrl = ULA_SUB;
          FN_AND:  ula_ctrl = ULA_AND;
          FN_OR:   ula_ctrl = ULA_OR;
          FN_SLT:  ula_ctrl = ULA_SLT;
          default: begin
            ula_ctrl      = ULA_ADD;
            illegal_funct = 1'b1;
          end
        endcase
      end
      default: ula_ctrl = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the 8-bit multicycle MIPS datapath. The control word
// is registered from the next state so it is valid at the start of each state.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] Opcode,
  input  logic [FN_W-1:0] Funct,
  input  logic            FlagZ,
  output logic [2:0]      ULAControl,
  output logic            IorD,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSrc,
  output logic            PCEn,
  output logic            Illegal,
  output logic [3:0]      State
);

  state_t     state_r;
  state_t     next_s;
  logic       armed_r;
  logic       illfn_r;
  ctrl_t      ctrl_r;
  aluop_t     aluop_s;
  logic [2:0] ula_s;
  logic       illfn_s;
  logic       state_ok_s;

  // Next-state selection; holds FETCH until armed.
  always_comb begin
    next_s = S_FETCH;
    if (!armed_r) begin
      next_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: next_s = S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: next_s = S_MEMADR;
            OP_RTYPE:     next_s = S_EXEC;
            OP_BEQ:       next_s = S_BRANCH;
            OP_ADDI:      next_s = S_ADDIEX;
            OP_J:         next_s = S_JUMP;
            default:      next_s = S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (Opcode == OP_SW) begin
            next_s = S_MEMWR;
          end else begin
            next_s = S_MEMRD;
          end
        end
        S_MEMRD: next_s = S_MEMWB;
        S_EXEC: begin
          if (illfn_r) begin
            next_s = S_FETCH;
          end else begin
            next_s = S_ALUWB;
          end
        end
        S_ADDIEX: next_s = S_ADDIWB;
        default:  next_s = S_FETCH;
      endcase
    end
  end

  // ALU operation class for the state being entered.
  always_comb begin
    aluop_s = ALUOP_ADD;
    if (next_s == S_EXEC) begin
      aluop_s = ALUOP_FUNCT;
    end else if (next_s == S_BRANCH) begin
      aluop_s = ALUOP_SUB;
    end else begin
      aluop_s = ALUOP_ADD;
    end
  end

  alu_decoder u_alu_decoder (
    .funct         (Funct),
    .aluop         (aluop_s),
    .ula_ctrl      (ula_s),
    .illegal_funct (illfn_s)
  );

  // State, arming flag and registered control word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      armed_r <= 1'b0;
      illfn_r <= 1'b0;
      ctrl_r  <= ctrl_reset();
    end else begin
      armed_r <= 1'b1;
      state_r <= next_s;
      illfn_r <= illfn_s;
      ctrl_r  <= ctrl_for(next_s, ula_s);
    end
  end

  // Corrupted state codes must never let a write enable through.
  assign state_ok_s = armed_r && (state_r <= S_JUMP);

  assign ULAControl = ctrl_r.ula;
  assign IorD       = ctrl_r.iord;
  assign RegDst     = ctrl_r.regdst;
  assign MemtoReg   = ctrl_r.memtoreg;
  assign ALUSrcA    = ctrl_r.alusrca;
  assign ALUSrcB    = ctrl_r.alusrcb;
  assign PCSrc      = ctrl_r.pcsrc;
  assign IRWrite    = state_ok_s & ctrl_r.irwrite;
  assign RegWrite   = state_ok_s & ctrl_r.regwrite;
  assign MemWrite   = state_ok_s & ctrl_r.memwrite;
  assign PCEn       = state_ok_s & (ctrl_r.pcwrite | (ctrl_r.branch & FlagZ));
  assign Illegal    = armed_r & (((state_r == S_DECODE) & ~op_legal(Opcode)) |
                                 ((state_r == S_EXEC) & illfn_r));
  assign State      = state_r;

endmodule
